proc_run_sequencer: RTL and testbench

Autonomous controller that drives the processor's DIN/Run/Done interface from an instruction memory.
- Fetches words from a synchronous 1-cycle-latency ROM, starting at Base_addr.
- Presents each word on DIN with a 1-cycle Run pulse, then waits for Done before fetching the next word.
- Stops after the word at End_addr, on a Stop request, or on a Done timeout.
- Sits between the program ROM and the processor; replaces manual Run/DIN switches.

---
 rtl/proc_run_sequencer_pkg.sv | 20 ++
 rtl/proc_run_sequencer_if.sv | 15 +
 rtl/proc_run_sequencer_seq_wdog.sv | 27 ++
 rtl/proc_run_sequencer.sv | 127 ++++++++++++
 tb/tb_proc_run_sequencer.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/proc_run_sequencer_pkg.sv
// Shared definitions for the instruction-memory driven Run/DIN sequencer.
package proc_run_sequencer_pkg;

   localparam int DEF_TIMEOUT = 15;
   localparam int WDOG_W      = 8;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_FETCH    = 3'd1,
      ST_WAIT_MEM = 3'd2,
      ST_ISSUE    = 3'd3,
      ST_EXEC     = 3'd4,
      ST_ERROR    = 3'd5
   } state_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/proc_run_sequencer_if.sv
// ROM and processor-side bus of the sequencer; master is the sequencer.
interface proc_run_sequencer_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);
   logic [ADDR_W-1:0] Mem_addr;
   logic              Mem_rd;
   logic [DATA_W-1:0] Mem_q;
   logic [DATA_W-1:0] DIN;
   logic              Run;
   logic              Done;

   modport master (output Mem_addr, Mem_rd, DIN, Run, input Mem_q, Done);
   modport slave  (input Mem_addr, Mem_rd, DIN, Run, output Mem_q, Done);
endinterface

// File: rtl/proc_run_sequencer_seq_wdog.sv
// Clearable 8-bit up-counter flagging the last permitted EXEC cycle.
module seq_wdog
   import proc_run_sequencer_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);
   logic [WDOG_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr)     cnt_d = '0;
      else if (en) cnt_d = cnt_q + WDOG_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign expired = (cnt_q == WDOG_W'(TIMEOUT - 1));
endmodule

// File: rtl/proc_run_sequencer.sv
// Walks a ROM from Base_addr to End_addr, issuing each word to the processor
// with a one-cycle Run and waiting for Done (bounded by a watchdog).
module proc_run_sequencer
   import proc_run_sequencer_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                 Clock,
   input  logic                 Resetn,
   input  logic                 Start,
   input  logic                 Stop,
   input  logic [ADDR_W-1:0]    Base_addr,
   input  logic [ADDR_W-1:0]    End_addr,
   proc_run_sequencer_if.master bus,
   output logic                 Busy,
   output logic                 Seq_done,
   output logic                 Err,
   output logic [15:0]          Instr_count
);
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] end_q, end_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic [15:0]       cnt_q, cnt_d;
   logic              stop_pend_q, stop_pend_d;
   logic              seq_done_q, seq_done_d;
   logic              err_q, err_d;
   logic              wdog_expired;
   logic              halt_now;

   seq_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clk     (Clock),
      .rst_n   (Resetn),
      .clr     (state_q == ST_ISSUE),
      .en      (state_q == ST_EXEC),
      .expired (wdog_expired)
   );

   // A Stop arriving together with Done still ends the run after this word.
   assign halt_now = (pc_q == end_q) || stop_pend_q || Stop;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      end_d       = end_q;
      din_d       = din_q;
      cnt_d       = cnt_q;
      stop_pend_d = stop_pend_q;
      seq_done_d  = 1'b0;
      err_d       = err_q;
      case (state_q)
         ST_IDLE, ST_ERROR: begin
            if (Start) begin
               pc_d        = Base_addr;
               end_d       = End_addr;
               cnt_d       = '0;
               stop_pend_d = Stop;
               err_d       = 1'b0;
               state_d     = ST_FETCH;
            end
         end
         ST_FETCH: begin
            stop_pend_d = stop_pend_q | Stop;
            state_d     = ST_WAIT_MEM;
         end
         ST_WAIT_MEM: begin
            stop_pend_d = stop_pend_q | Stop;
            din_d       = bus.Mem_q;
            state_d     = ST_ISSUE;
         end
         ST_ISSUE: begin
            stop_pend_d = stop_pend_q | Stop;
            state_d     = ST_EXEC;
         end
         ST_EXEC: begin
            stop_pend_d = stop_pend_q | Stop;
            if (bus.Done) begin
               cnt_d = sat_inc16(cnt_q);
               if (halt_now) begin
                  seq_done_d = 1'b1;
                  state_d    = ST_IDLE;
               end else begin
                  pc_d    = pc_q + ADDR_W'(1);
                  state_d = ST_FETCH;
               end
            end else if (wdog_expired) begin
               err_d   = 1'b1;
               state_d = ST_ERROR;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q     <= ST_IDLE;
         pc_q        <= '0;
         end_q       <= '0;
         din_q       <= '0;
         cnt_q       <= '0;
         stop_pend_q <= 1'b0;
         seq_done_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         end_q       <= end_d;
         din_q       <= din_d;
         cnt_q       <= cnt_d;
         stop_pend_q <= stop_pend_d;
         seq_done_q  <= seq_done_d;
         err_q       <= err_d;
      end
   end

   assign bus.Mem_addr = pc_q;
   assign bus.Mem_rd   = (state_q == ST_FETCH);
   assign bus.Run      = (state_q == ST_ISSUE);
   assign bus.DIN      = din_q;
   assign Busy         = (state_q != ST_IDLE) && (state_q != ST_ERROR);
   assign Seq_done     = seq_done_q;
   assign Err          = err_q;
   assign Instr_count  = cnt_q;
endmodule

// File: tb/tb_proc_run_sequencer.sv
// Table-driven sequences against a ROM/processor model with an address/DIN scoreboard.
module tb_proc_run_sequencer;
   localparam int AW  = 8;
   localparam int DW  = 16;
   localparam int TMO = 15;

   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0;
   logic [7:0]  base_addr = '0, end_addr = '0;
   logic        busy, seq_done, err;
   logic [15:0] instr_count;

   proc_run_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   proc_run_sequencer #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
      .Clock(clk), .Resetn(rst_n), .Start(start), .Stop(stop),
      .Base_addr(base_addr), .End_addr(end_addr), .bus(bus),
      .Busy(busy), .Seq_done(seq_done), .Err(err), .Instr_count(instr_count)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] rom_word(input logic [7:0] a);
      return {~a, a ^ 8'h5A};
   endfunction

   // Synchronous ROM, one cycle latency
   logic [15:0] mem_q_r = '0;
   always @(posedge clk) if (bus.Mem_rd) mem_q_r <= rom_word(bus.Mem_addr);
   assign bus.Mem_q = mem_q_r;

   // Processor: Done in the done_dly-th EXEC cycle after Run (0 = never)
   int done_dly = 0;
   int pcnt = 0;
   bit force_done = 1'b0;
   always @(posedge clk) begin
      if (bus.Run)        pcnt <= done_dly;
      else if (pcnt != 0) pcnt <= pcnt - 1;
   end
   assign bus.Done = (pcnt == 1) || force_done;

   // Scoreboard
   logic [7:0]  exp_addr_q[$];
   logic [15:0] exp_din_q[$];
   logic        run_prev = 1'b0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.Mem_rd) begin
            chk("mem_rd_expected", exp_addr_q.size() != 0, 1);
            if (exp_addr_q.size() != 0) chk("mem_addr", bus.Mem_addr, exp_addr_q.pop_front());
         end
         if (bus.Run) begin
            chk("run_single", run_prev, 0);
            chk("run_expected", exp_din_q.size() != 0, 1);
            if (exp_din_q.size() != 0) chk("din", bus.DIN, exp_din_q.pop_front());
         end
      end
      run_prev = bus.Run;
   end

   typedef struct {
      logic [7:0] base;
      logic [7:0] endp;
      int         stop_after;   // -1: Stop with Start, 0: none, n: during EXEC of n-th word
      int         dly;
      bit         poke;         // Start with bogus base while busy
      int         exp_count;
      bit         exp_sd;
      bit         exp_err;
   } vec_t;

   task automatic run_vec(input vec_t v);
      int n_issue, cyc, run_seen, first_run, last_run, end_cyc;
      bit sd_seen, er_seen;
      n_issue = v.exp_err ? 1 : v.exp_count;
      for (int i = 0; i < n_issue; i++) begin
         exp_addr_q.push_back(v.base + 8'(i));
         exp_din_q.push_back(rom_word(v.base + 8'(i)));
      end
      done_dly = v.dly;
      run_seen = 0; first_run = -1; last_run = -10; end_cyc = -1;
      sd_seen = 1'b0; er_seen = 1'b0;
      @(negedge clk);
      start = 1'b1; base_addr = v.base; end_addr = v.endp; stop = (v.stop_after < 0);
      @(negedge clk);
      cyc = 1;
      start = 1'b0; stop = 1'b0;
      chk("start_err_clear", err, 0);
      chk("start_busy", busy, 1);
      chk("start_mem_rd", bus.Mem_rd, 1);
      while (!sd_seen && !er_seen && cyc < 400) begin
         start = 1'b0; stop = 1'b0;
         if (bus.Run) begin
            run_seen++;
            if (first_run < 0) first_run = cyc;
            else chk("run_period", cyc - last_run, v.dly + 3);
            last_run = cyc;
         end else if (run_seen > 0 && last_run == cyc - 1) begin
            if (v.stop_after > 0 && run_seen == v.stop_after) stop = 1'b1;
            if (v.poke && run_seen == 1) begin
               start = 1'b1; base_addr = 8'hAA; end_addr = 8'hAA;
            end
         end
         if (seq_done) begin sd_seen = 1'b1; end_cyc = cyc; end
         if (err)      begin er_seen = 1'b1; end_cyc = cyc; end
         if (!sd_seen && !er_seen) begin
            @(negedge clk);
            cyc++;
         end
      end
      start = 1'b0; stop = 1'b0;
      chk("seq_ended", sd_seen || er_seen, 1);
      chk("first_run_latency", first_run, 3);
      chk("seq_done_seen", sd_seen, v.exp_sd);
      chk("err_seen", er_seen, v.exp_err);
      chk("instr_count", instr_count, v.exp_count);
      chk("busy_after", busy, 0);
      chk("run_count", run_seen, n_issue);
      chk("sb_empty", exp_addr_q.size(), 0);
      if (sd_seen) chk("seq_done_time", end_cyc - last_run, v.dly + 1);
      if (er_seen) chk("err_time", end_cyc - last_run, TMO + 1);
      @(negedge clk);
      if (sd_seen) chk("seq_done_pulse", seq_done, 0);
      if (er_seen) chk("err_sticky", err, 1);
      chk("idle_busy", busy, 0);
      @(negedge clk);
   endtask

   vec_t vecs[10];

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not end");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{8'h10, 8'h12,  0,  2, 1'b1, 3, 1'b1, 1'b0};
      vecs[1] = '{8'h05, 8'h05,  0,  2, 1'b0, 1, 1'b1, 1'b0};
      vecs[2] = '{8'hFE, 8'h01,  0,  2, 1'b0, 4, 1'b1, 1'b0};
      vecs[3] = '{8'h20, 8'h24,  2,  2, 1'b0, 2, 1'b1, 1'b0};
      vecs[4] = '{8'h80, 8'h85, -1,  3, 1'b0, 1, 1'b1, 1'b0};
      vecs[5] = '{8'h30, 8'h31,  0, 15, 1'b0, 2, 1'b1, 1'b0};
      vecs[6] = '{8'h40, 8'h41,  0,  1, 1'b0, 2, 1'b1, 1'b0};
      vecs[7] = '{8'h50, 8'h52,  0,  0, 1'b0, 0, 1'b0, 1'b1};
      vecs[8] = '{8'h60, 8'h61,  0,  2, 1'b0, 2, 1'b1, 1'b0};
      vecs[9] = '{8'h70, 8'h70,  0, 16, 1'b0, 0, 1'b0, 1'b1};

      // Reset state, with a spurious Done present
      force_done = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_run", bus.Run, 0);
      chk("rst_mem_rd", bus.Mem_rd, 0);
      chk("rst_din", bus.DIN, 0);
      chk("rst_mem_addr", bus.Mem_addr, 0);
      chk("rst_err", err, 0);
      chk("rst_seq_done", seq_done, 0);
      chk("rst_count", instr_count, 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_done_ignored", busy, 0);
      force_done = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 10; i++) run_vec(vecs[i]);

      // Reset in the middle of an instruction
      exp_addr_q.push_back(8'h90);
      exp_din_q.push_back(rom_word(8'h90));
      done_dly = 0;
      @(negedge clk);
      start = 1'b1; base_addr = 8'h90; end_addr = 8'h95;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 10 && !bus.Run; k++) @(negedge clk);
      chk("rx_run_reached", bus.Run, 1);
      @(negedge clk);
      chk("rx_in_exec", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("rx_busy", busy, 0);
      chk("rx_run", bus.Run, 0);
      chk("rx_mem_rd", bus.Mem_rd, 0);
      chk("rx_din", bus.DIN, 0);
      chk("rx_mem_addr", bus.Mem_addr, 0);
      chk("rx_count", instr_count, 0);
      chk("rx_seq_done", seq_done, 0);
      exp_addr_q.delete();
      exp_din_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      force_done = 1'b1;
      repeat (3) @(negedge clk);
      force_done = 1'b0;
      chk("rx_idle_busy", busy, 0);
      chk("rx_idle_count", instr_count, 0);
      chk("rx_idle_seq_done", seq_done, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
